spi_frame_regs: RTL and testbench

- Frame decoder and register file directly downstream of spi_slave.
- Consumes received SPI bytes (rx_byte/rx_strobe) and assembles 7-byte frames: cmd, addr, data[31:24], data[23:16], data[15:8], data[7:0], crc8.
- Checks CRC and executes read/write commands on a 32-bit register bank whose outputs configure hwag (enable, dwell, coil angles).
- Builds the response frame that spi_slave shifts out during the next frame.

---
 rtl/spi_frame_regs.sv | 207 ++++++++++++++++++++
 tb/tb_spi_frame_regs.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_regs.sv
// Frame decoder and register bank behind spi_slave: assembles 7-byte frames,
// checks CRC-8, executes read/write and prepares the response frame.
module spi_frame_regs #(
  parameter int unsigned NREG      = 4,
  parameter logic [7:0]  STAT_ADDR = 8'h7F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_ss,
  input  logic                 rx_strobe,
  input  logic [7:0]           rx_byte,
  output logic [7:0]           tx_byte,
  output logic [NREG*32-1:0]   reg_q,
  output logic                 wr_pulse,
  output logic [7:0]           wr_addr,
  output logic                 frame_ok,
  output logic                 frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_EXEC,
    S_WAIT_SS
  } state_t;

  state_t state, state_nxt;

  logic [2:0]  bcnt;
  logic [7:0]  crc;
  logic [7:0]  fbuf [7];
  logic [55:0] resp;
  logic [31:0] regs [NREG];
  logic [15:0] frame_cnt;
  logic [7:0]  cmd_err_cnt;
  logic [7:0]  crc_err_cnt;

  logic        rx_take;
  logic        short_frame;
  logic [7:0]  cmd;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] status;
  logic        addr_rw;
  logic        crc_good;
  logic        is_rd;
  logic        is_wr;
  logic [47:0] resp_body;
  logic [7:0]  resp_crc;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] crc8_48(input logic [47:0] v);
    logic [7:0] c;
    c = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      c = crc8_byte(c, v[47-8*i -: 8]);
    end
    return c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (rx_take) state_nxt = S_RECV;
      S_RECV: begin
        if (short_frame)                    state_nxt = S_IDLE;
        else if (rx_take && bcnt == 3'd6)   state_nxt = S_CHECK;
      end
      S_CHECK:   state_nxt = S_EXEC;
      S_EXEC:    state_nxt = S_WAIT_SS;
      S_WAIT_SS: if (spi_ss) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    rx_take     = 1'b0;
    short_frame = 1'b0;
    unique case (state)
      S_IDLE: rx_take = rx_strobe & ~spi_ss;
      S_RECV: begin
        short_frame = spi_ss;
        rx_take     = rx_strobe & ~spi_ss;
      end
      default: ;
    endcase

    unique case (bcnt)
      3'd0:    tx_byte = resp[55:48];
      3'd1:    tx_byte = resp[47:40];
      3'd2:    tx_byte = resp[39:32];
      3'd3:    tx_byte = resp[31:24];
      3'd4:    tx_byte = resp[23:16];
      3'd5:    tx_byte = resp[15:8];
      3'd6:    tx_byte = resp[7:0];
      default: tx_byte = '0;
    endcase

    cmd      = fbuf[0];
    addr     = fbuf[1];
    wdata    = {fbuf[2], fbuf[3], fbuf[4], fbuf[5]};
    status   = {crc_err_cnt, cmd_err_cnt, frame_cnt};
    crc_good = (crc == fbuf[6]);
    addr_rw  = 1'b0;
    rdata    = status;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (addr == 8'(i)) begin
        addr_rw = 1'b1;
        rdata   = regs[i];
      end
    end
    is_rd = (cmd == 8'h01) && (addr_rw || addr == STAT_ADDR);
    is_wr = (cmd == 8'h02) && addr_rw;
    if (crc_good && (is_rd || is_wr)) resp_body = {cmd | 8'h80, addr, is_wr ? wdata : rdata};
    else                              resp_body = {8'hEE, addr, 32'h0};
    resp_crc = crc8_48(resp_body);
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      reg_q[i*32 +: 32] = regs[i];
    end
  end

  // Decode is combinational during CHECK and committed on the CHECK->EXEC edge,
  // so pulses and reg_q are visible together in the EXEC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt        <= '0;
      crc         <= '0;
      fbuf        <= '{default: '0};
      resp        <= '0;
      regs        <= '{default: '0};
      frame_cnt   <= '0;
      cmd_err_cnt <= '0;
      crc_err_cnt <= '0;
      wr_pulse    <= 1'b0;
      wr_addr     <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (short_frame) begin
        bcnt      <= '0;
        crc       <= '0;
        frame_err <= 1'b1;
        if (cmd_err_cnt != 8'hFF) cmd_err_cnt <= cmd_err_cnt + 8'd1;
      end else if (rx_take) begin
        fbuf[bcnt] <= rx_byte;
        if (bcnt != 3'd6) begin
          crc  <= crc8_byte(crc, rx_byte);
          bcnt <= bcnt + 3'd1;
        end
      end

      if (state == S_CHECK) begin
        resp <= {resp_body, resp_crc};
        if (!crc_good) begin
          frame_err <= 1'b1;
          if (crc_err_cnt != 8'hFF) crc_err_cnt <= crc_err_cnt + 8'd1;
        end else if (is_wr) begin
          for (int unsigned i = 0; i < NREG; i++) begin
            if (addr == 8'(i)) regs[i] <= wdata;
          end
          wr_pulse  <= 1'b1;
          wr_addr   <= addr;
          frame_ok  <= 1'b1;
          frame_cnt <= frame_cnt + 16'd1;
        end else if (is_rd) begin
          frame_ok  <= 1'b1;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          frame_err <= 1'b1;
          if (cmd_err_cnt != 8'hFF) cmd_err_cnt <= cmd_err_cnt + 8'd1;
        end
      end

      if (state == S_WAIT_SS && spi_ss) begin
        bcnt <= '0;
        crc  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_regs.sv
// Directed bench for spi_frame_regs with a frame-level reference model and a
// per-cycle compare process.
module tb_spi_frame_regs;
  localparam int unsigned NREG = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                spi_ss = 1'b1;
  logic                rx_strobe = 1'b0;
  logic [7:0]          rx_byte = '0;
  logic [7:0]          tx_byte;
  logic [NREG*32-1:0]  reg_q;
  logic                wr_pulse;
  logic [7:0]          wr_addr;
  logic                frame_ok;
  logic                frame_err;

  always #5 clk = ~clk;

  spi_frame_regs #(.NREG(NREG), .STAT_ADDR(8'h7F)) dut (
    .clk(clk), .rst(rst), .spi_ss(spi_ss), .rx_strobe(rx_strobe), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .reg_q(reg_q), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  logic [31:0] m_reg [NREG];
  logic [7:0]  m_resp [7];
  logic [7:0]  m_crce, m_cce;
  logic [15:0] m_fc;
  logic        e_ok, e_err, e_wr;
  logic [7:0]  e_waddr;
  logic        pend_v = 1'b0;
  logic        pend_short = 1'b0;
  int          pend_cyc = 0;
  logic [7:0]  pend_fr [7];
  logic        tx_watch = 1'b0;
  int          tx_slot = 0;
  logic [7:0]  cap [7];
  logic [7:0]  fb [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [47:0] msg);
    logic [7:0] c;
    c = '0;
    for (int i = 47; i >= 0; i--) begin
      if (c[7] ^ msg[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else               c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    for (int i = 0; i < 7; i++) m_resp[i] = '0;
    m_crce = '0; m_cce = '0; m_fc = '0;
    pend_v = 1'b0;
  endtask

  task automatic model_apply();
    logic [7:0]  c, a;
    logic [31:0] d;
    logic [47:0] body;
    if (pend_short) begin
      e_err = 1'b1;
      if (m_cce != 8'hFF) m_cce++;
      return;
    end
    c = pend_fr[0];
    a = pend_fr[1];
    d = {pend_fr[2], pend_fr[3], pend_fr[4], pend_fr[5]};
    if (crc8({pend_fr[0], pend_fr[1], pend_fr[2], pend_fr[3], pend_fr[4], pend_fr[5]}) != pend_fr[6]) begin
      e_err = 1'b1;
      if (m_crce != 8'hFF) m_crce++;
      body = {8'hEE, a, 32'h0};
    end else if (c == 8'h01 && a == 8'h7F) begin
      body = {8'h81, a, m_crce, m_cce, m_fc};
      e_ok = 1'b1; m_fc++;
    end else if (c == 8'h01 && a < 8'(NREG)) begin
      body = {8'h81, a, m_reg[a[1:0]]};
      e_ok = 1'b1; m_fc++;
    end else if (c == 8'h02 && a < 8'(NREG)) begin
      m_reg[a[1:0]] = d;
      body = {8'h82, a, d};
      e_ok = 1'b1; e_wr = 1'b1; e_waddr = a; m_fc++;
    end else begin
      e_err = 1'b1;
      if (m_cce != 8'hFF) m_cce++;
      body = {8'hEE, a, 32'h0};
    end
    for (int k = 0; k < 6; k++) m_resp[k] = body[47-8*k -: 8];
    m_resp[6] = crc8(body);
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      e_ok = 1'b0; e_err = 1'b0; e_wr = 1'b0;
      if (pend_v && cyc == pend_cyc) begin
        pend_v = 1'b0;
        model_apply();
      end
      chk("frame_ok", 32'(frame_ok), 32'(e_ok));
      chk("frame_err", 32'(frame_err), 32'(e_err));
      chk("wr_pulse", 32'(wr_pulse), 32'(e_wr));
      if (e_wr) chk("wr_addr", 32'(wr_addr), 32'(e_waddr));
      for (int i = 0; i < NREG; i++) chk($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32], m_reg[i]);
      if (tx_watch) chk($sformatf("tx_byte slot%0d", tx_slot), 32'(tx_byte), 32'(m_resp[tx_slot]));
    end
  end

  task automatic set_frame(input logic [47:0] body, input logic fix, input logic [7:0] last);
    for (int k = 0; k < 6; k++) fb[k] = body[47-8*k -: 8];
    fb[6] = fix ? last : crc8(body);
    fb[7] = 8'hAA;
    fb[8] = 8'hBB;
  endtask

  task automatic send_byte(input logic [7:0] b, input int slot, input logic ss_rise);
    if (slot < 7) begin
      @(negedge clk);
      tx_slot = slot; tx_watch = 1'b1;
    end
    @(negedge clk);
    tx_watch = 1'b0;
    if (slot < 7) cap[slot] = tx_byte;
    rx_strobe = 1'b1; rx_byte = b;
    if (ss_rise) begin
      spi_ss = 1'b1; pend_short = 1'b1; pend_cyc = cyc + 1; pend_v = 1'b1;
    end else if (slot == 6) begin
      pend_short = 1'b0; pend_cyc = cyc + 2; pend_v = 1'b1;
    end
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  // mode 0: normal, 1: ss rises after last byte, 2: ss rises with last strobe
  task automatic send_frame(input int n, input int mode);
    for (int k = 0; k < 7; k++) begin
      pend_fr[k] = fb[k];
      cap[k] = 8'h5A;
    end
    @(negedge clk);
    spi_ss = 1'b0;
    for (int k = 0; k < n; k++) send_byte(fb[k], k, (mode == 2 && k == n - 1));
    if (mode == 1) begin
      spi_ss = 1'b1; pend_short = 1'b1; pend_cyc = cyc + 1; pend_v = 1'b1;
    end
    repeat (4) @(negedge clk);
    spi_ss = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx_byte", 32'(tx_byte), 32'h0);
    chk("rst_reg_q_zero", 32'(|reg_q), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("crc_model_pin", 32'(crc8(48'h02_01_00_00_00_01)), 32'h37);

    // Write reg1 = 1
    set_frame(48'h02_01_00_00_00_01, 1'b1, 8'h37);
    send_frame(7, 0);
    chk("w1_reg1", reg_q[63:32], 32'h1);

    // Bad CRC
    set_frame(48'h02_01_00_00_00_01, 1'b1, 8'h38);
    send_frame(7, 0);
    chk("badcrc_tx0", 32'(cap[0]), 32'h82);
    chk("badcrc_tx1", 32'(cap[1]), 32'h01);
    chk("badcrc_tx5", 32'(cap[5]), 32'h01);
    chk("badcrc_reg1", reg_q[63:32], 32'h1);

    // Read back reg1
    set_frame(48'h01_01_00_00_00_00, 1'b0, 8'h00);
    send_frame(7, 0);
    chk("rd_tx0_err", 32'(cap[0]), 32'hEE);

    // Illegal cmd, then write to status address
    set_frame(48'h05_01_00_00_00_00, 1'b0, 8'h00);
    send_frame(7, 0);
    chk("ill_tx0", 32'(cap[0]), 32'h81);
    chk("ill_tx5", 32'(cap[5]), 32'h01);
    set_frame(48'h02_7F_00_00_00_05, 1'b0, 8'h00);
    send_frame(7, 0);
    chk("w7f_tx0", 32'(cap[0]), 32'hEE);

    // Read status
    set_frame(48'h01_7F_00_00_00_00, 1'b0, 8'h00);
    send_frame(7, 0);
    chk("rd7f_tx1", 32'(cap[1]), 32'h7F);

    // Short frame: response must stay the status read
    set_frame(48'h02_02_11_22_33_44, 1'b0, 8'h00);
    send_frame(3, 1);
    chk("short_tx0", 32'(cap[0]), 32'h81);
    chk("short_tx2", 32'(cap[2]), 32'h01);

    // Valid write after short frame; captures the status response
    set_frame(48'h02_03_DE_AD_BE_EF, 1'b0, 8'h00);
    send_frame(7, 0);
    chk("stat_crc_err", 32'(cap[2]), 32'h01);
    chk("stat_cmd_err", 32'(cap[3]), 32'h02);
    chk("stat_fc_hi", 32'(cap[4]), 32'h00);
    chk("stat_fc_lo", 32'(cap[5]), 32'h02);
    chk("w3_reg3", reg_q[127:96], 32'hDEADBEEF);

    // Strobe and ss rising in the same cycle
    set_frame(48'h02_00_99_99_99_99, 1'b0, 8'h00);
    send_frame(2, 2);
    chk("same_tx0", 32'(cap[0]), 32'h82);
    chk("same_tx1", 32'(cap[1]), 32'h03);

    // Over-length frame: 9 bytes, only first 7 decoded
    set_frame(48'h02_00_12_34_56_78, 1'b0, 8'h00);
    send_frame(9, 0);
    chk("ovl_tx2", 32'(cap[2]), 32'hDE);
    chk("ovl_reg0", reg_q[31:0], 32'h12345678);

    // Reset between byte 3 and 4
    set_frame(48'h02_01_AB_CD_EF_01, 1'b0, 8'h00);
    @(negedge clk);
    spi_ss = 1'b0;
    for (int k = 0; k < 3; k++) send_byte(fb[k], k, 1'b0);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("midrst_reg_q_zero", 32'(|reg_q), 32'h0);
    chk("midrst_tx", 32'(tx_byte), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    spi_ss = 1'b1;
    repeat (3) @(negedge clk);

    // Status after reset
    set_frame(48'h01_7F_00_00_00_00, 1'b0, 8'h00);
    send_frame(7, 0);
    chk("post_rst_tx0", 32'(cap[0]), 32'h00);
    set_frame(48'h01_00_00_00_00_00, 1'b0, 8'h00);
    send_frame(7, 0);
    chk("post_rst_stat_tx0", 32'(cap[0]), 32'h81);
    chk("post_rst_stat", {cap[2], cap[3], cap[4], cap[5]}, 32'h0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
